// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM encoding and baud timing helpers for the UART transmitter
package uart_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

  // Never narrower than one bit, even for a 1-cycle symbol
  function automatic int baud_cnt_width(input int set);
    return (set > 1) ? $clog2(set) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with wrap-bit pointers and combinational head output
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - buffered 8N1 UART transmitter with ready/valid byte input
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic       serial_out,
  output logic       tx_busy
);
  localparam int SET   = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
  localparam int CNT_W = baud_cnt_width(SET);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SET - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             out_q, out_d;
  logic             busy_q;
  logic             ready_en_q;
  logic             fifo_full, fifo_empty, fifo_pop, fifo_push, bit_end;
  logic [7:0]       fifo_dout;

  // ready comes only from flops, so there is no path from data_in_valid
  assign data_in_ready = ready_en_q && !fifo_full;
  assign fifo_push     = data_in_valid && data_in_ready;
  assign serial_out    = out_q;
  assign tx_busy       = busy_q;
  assign bit_end       = (cnt_q == CNT_LAST);

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .din_i   (data_in),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    tx_shift_d = tx_shift_q;
    out_d      = out_q;
    fifo_pop   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        out_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          tx_shift_d = fifo_dout;
          cnt_d      = '0;
          bit_d      = '0;
          state_d    = ST_START;
          out_d      = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = ST_DATA;
          out_d   = tx_shift_q[0];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            out_d   = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            out_d = tx_shift_q[bit_q + 3'd1];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          bit_d = '0;
          // Chain straight into the next start bit when more data is waiting
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            tx_shift_d = fifo_dout;
            state_d    = ST_START;
            out_d      = 1'b0;
          end else begin
            state_d = ST_IDLE;
            out_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        out_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      tx_shift_q <= '0;
      out_q      <= 1'b1;
      busy_q     <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      tx_shift_q <= tx_shift_d;
      out_q      <= out_d;
      busy_q     <= (state_q != ST_IDLE) || !fifo_empty;
      ready_en_q <= 1'b1;
    end
  end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- Serial transmitter on the CPU side of the UART link; drives the line that a host or bench receiver samples.
- Accepts bytes over a ready/valid interface into a small FIFO.
- Serializes each byte as 8N1: start bit, 8 data bits LSB first, one stop bit.
- Sits behind the CPU's memory-mapped UART TX register. The CPU polls `data_in_ready` before storing a byte.

Parameters:
- CLOCK_FREQ, 50_000_000, clk frequency in Hz.
- BAUD_RATE, 115_200, line rate in bits/s.
- FIFO_DEPTH, 4, byte buffer depth; power of two, ≥2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset. Assertion is async; deassertion is sampled on clk.
- data_in  input  8  byte to transmit.
- data_in_valid  input  1  producer offers data_in this cycle.
- data_in_ready  output  1  FIFO can accept a byte this cycle.
- serial_out  output  1  UART line, idle high.
- tx_busy  output  1  FIFO non-empty or a frame in progress.

Behaviour:
- SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE, integer division (434 at defaults). Each bit is held exactly SYMBOL_EDGE_TIME cycles.
- Reset (rst=0) values:
  - serial_out=1, data_in_ready=0, tx_busy=0.
  - FIFO emptied, FSM in IDLE, baud and bit counters at 0.
  - data_in_ready rises the first cycle after rst returns high.
- Reset during a frame aborts it immediately; serial_out goes to 1 asynchronously. Buffered bytes are lost.
- Enqueue: a byte is written on a rising edge where data_in_valid && data_in_ready.
- data_in_ready = !fifo_full, registered-full based. No combinational path from data_in_valid.
- FSM states and transitions:
  - IDLE: serial_out=1. If the FIFO is non-empty, pop the head into shift register `tx_shift`, clear the counters, go to START.
  - START: serial_out=0 for SYMBOL_EDGE_TIME cycles, then go to DATA with bit_idx=0.
  - DATA: serial_out=tx_shift[bit_idx]. After each SYMBOL_EDGE_TIME cycles, bit_idx increments. Leaving bit 7 goes to STOP.
  - STOP: serial_out=1 for SYMBOL_EDGE_TIME cycles. If the FIFO is non-empty, pop and go straight to START (no idle gap), else go to IDLE.
- Latency from enqueue into an empty, idle block: the byte is written at edge N, popped at edge N+1, and the start bit appears on serial_out after edge N+1. The start bit is therefore visible 1 cycle after the write.
- serial_out is driven from a flop; no glitches.
- Frame length is 10*SYMBOL_EDGE_TIME cycles.
- Simultaneous push and pop in one cycle:
  - Both take effect; occupancy is unchanged.
  - A push on a full FIFO in the same cycle as a pop is NOT accepted, because ready reflects the registered full flag.
- Pointer wrap: pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally.
  - full when the MSBs differ and the remaining bits are equal.
  - empty when the pointers are equal.
- tx_busy = (state != IDLE) || !fifo_empty, registered.
- A valid request while ready=0 is held off; the producer keeps data_in stable until accepted.

Decomposition:
- Shared package uart_pkg holds:
  - the state encoding (IDLE, START, DATA, STOP) as localparams;
  - the function computing SYMBOL_EDGE_TIME;
  - the counter width clog2(SYMBOL_EDGE_TIME).
- One natural sub-module: sync_fifo (width 8, depth FIFO_DEPTH, same clk/rst). It provides push/pop/full/empty/dout, with dout valid from the head combinationally.

Test Plan:
- Use CLOCK_FREQ=1_000_000 and BAUD_RATE=100_000, giving 10 cycles/bit and a 100-cycle frame.
- Reset check: hold rst=0 → serial_out=1, ready=0, busy=0. Release → ready=1 on the next cycle.
- Single byte: push 8'hA5 → line shows 0,1,0,1,0,0,1,0,1,1, each bit held exactly 10 cycles. busy drops 1 cycle after the stop bit ends.
- Back-to-back: push 8'h00, 8'hFF, 8'h55 on consecutive cycles → three contiguous frames with no idle gap. A bench receiver decodes 00, FF, 55.
- Full FIFO:
  - push 6 bytes (01..06) with valid held high;
  - ready deasserts once the FIFO plus shift register hold 5 bytes;
  - byte 06 is accepted only after the first pop;
  - all 6 are received in order.
- Reset mid-frame: assert rst during data bit 3 of 8'h3C → serial_out=1 and busy=0 immediately. After release, a fresh push of 8'h81 transmits correctly.
- Defaults sanity: at the default parameters, a bit period measures 434 cycles (8680 ns at a 20 ns clock).
